// File: rtl/arm_sc_controller.sv
// Control unit for the single-cycle ARMv4 datapath: decode, NZCV flag register and condition check.
// Optional CMP support is enabled by defining CTRL_CMP_EN.
module arm_sc_controller #(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  output logic [1:0]   RegSrc,
  output logic         RegWrite,
  output logic [1:0]   ImmSrc,
  output logic         ALUSrc,
  output logic [1:0]   ALUControl,
  output logic         MemtoReg,
  output logic         MemWrite,
  output logic         PCSrc,
  output logic [3:0]   Flags,
  output logic         Undef
);

  logic [3:0] r_flags;

  logic [3:0] w_cond;
  logic [1:0] w_op;
  logic [5:0] w_funct;
  logic [3:0] w_rd;

  logic [1:0] w_regsrc;
  logic [1:0] w_immsrc;
  logic       w_alusrc;
  logic [1:0] w_aluctl;
  logic       w_memtoreg;
  logic       w_regw;
  logic       w_memw;
  logic       w_branch;
  logic [1:0] w_flagw;
  logic       w_dec_undef;

  logic       w_undef;
  logic       w_condex;
  logic       w_regw_q;
  logic       w_memw_q;
  logic       w_pcs;
  logic [1:0] w_flagw_q;
  logic       w_unused_rn;

  assign w_cond      = Instr[31:28];
  assign w_op        = Instr[27:26];
  assign w_funct     = Instr[25:20];
  assign w_rd        = Instr[15:12];
  assign w_unused_rn = ^Instr[19:16];

  // Main decoder: raw controls before undefined/condition qualification.
  always_comb begin
    w_regsrc    = 2'b00;
    w_immsrc    = 2'b00;
    w_alusrc    = 1'b0;
    w_aluctl    = 2'b00;
    w_memtoreg  = 1'b0;
    w_regw      = 1'b0;
    w_memw      = 1'b0;
    w_branch    = 1'b0;
    w_flagw     = 2'b00;
    w_dec_undef = 1'b0;
    case (w_op)
      2'b00: begin
        w_alusrc = w_funct[5];
        w_regw   = 1'b1;
        case (w_funct[4:1])
          4'b0100: begin w_aluctl = 2'b00; w_flagw = {w_funct[0], w_funct[0]}; end
          4'b0010: begin w_aluctl = 2'b01; w_flagw = {w_funct[0], w_funct[0]}; end
          4'b0000: begin w_aluctl = 2'b10; w_flagw = {w_funct[0], 1'b0}; end
          4'b1100: begin w_aluctl = 2'b11; w_flagw = {w_funct[0], 1'b0}; end
`ifdef CTRL_CMP_EN
          4'b1010: begin
            w_regw = 1'b0;
            if (w_funct[0]) begin
              w_aluctl = 2'b01;
              w_flagw  = 2'b11;
            end else begin
              w_dec_undef = 1'b1;
            end
          end
`endif
          default: w_dec_undef = 1'b1;
        endcase
      end
      2'b01: begin
        if (!w_funct[5] && w_funct[3]) begin
          w_immsrc   = 2'b01;
          w_alusrc   = 1'b1;
          w_aluctl   = 2'b00;
          if (w_funct[0]) begin
            w_regsrc   = 2'b00;
            w_memtoreg = 1'b1;
            w_regw     = 1'b1;
          end else begin
            w_regsrc = 2'b10;
            w_memw   = 1'b1;
          end
        end else begin
          w_dec_undef = 1'b1;
        end
      end
      2'b10: begin
        if (!w_funct[4]) begin
          w_regsrc = 2'b01;
          w_immsrc = 2'b10;
          w_alusrc = 1'b1;
          w_aluctl = 2'b00;
          w_branch = 1'b1;
        end else begin
          w_dec_undef = 1'b1;
        end
      end
      default: w_dec_undef = 1'b1;
    endcase
  end

  // Condition check uses the registered flags so an S instruction never gates itself.
  always_comb begin
    w_condex = 1'b0;
    case (w_cond)
      4'h0: w_condex = r_flags[2];
      4'h1: w_condex = ~r_flags[2];
      4'h2: w_condex = r_flags[1];
      4'h3: w_condex = ~r_flags[1];
      4'h4: w_condex = r_flags[3];
      4'h5: w_condex = ~r_flags[3];
      4'h6: w_condex = r_flags[0];
      4'h7: w_condex = ~r_flags[0];
      4'h8: w_condex = r_flags[1] & ~r_flags[2];
      4'h9: w_condex = ~r_flags[1] | r_flags[2];
      4'hA: w_condex = (r_flags[3] == r_flags[0]);
      4'hB: w_condex = (r_flags[3] != r_flags[0]);
      4'hC: w_condex = ~r_flags[2] & (r_flags[3] == r_flags[0]);
      4'hD: w_condex = r_flags[2] | (r_flags[3] != r_flags[0]);
      4'hE: w_condex = 1'b1;
      default: w_condex = 1'b0;
    endcase
  end

  assign w_undef   = w_dec_undef | (w_cond == 4'hF);
  assign w_regw_q  = w_regw & ~w_undef;
  assign w_memw_q  = w_memw & ~w_undef;
  assign w_pcs     = (w_branch & ~w_undef) | (w_regw_q & (w_rd == 4'hF));
  assign w_flagw_q = w_flagw & {2{~w_undef}};

  assign RegSrc     = w_undef ? 2'b00 : w_regsrc;
  assign ImmSrc     = w_undef ? 2'b00 : w_immsrc;
  assign ALUSrc     = w_alusrc & ~w_undef;
  assign ALUControl = w_undef ? 2'b00 : w_aluctl;
  assign MemtoReg   = w_memtoreg & ~w_undef;
  assign RegWrite   = w_regw_q & w_condex & ~reset;
  assign MemWrite   = w_memw_q & w_condex & ~reset;
  assign PCSrc      = w_pcs & w_condex & ~reset;
  assign Flags      = r_flags;
  assign Undef      = w_undef;

  // N,Z and C,V are written independently so logical ops keep the previous carry/overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= FLAG_RESET;
    end else begin
      if (w_flagw_q[1] & w_condex) r_flags[3:2] <= ALUFlags[3:2];
      if (w_flagw_q[0] & w_condex) r_flags[1:0] <= ALUFlags[1:0];
    end
  end

endmodule

// File: doc/arm_sc_controller.md
Name: arm_sc_controller

Overview:
Control unit for the single-cycle ARMv4 datapath. Decodes Instr[31:12] and drives every datapath control input. Holds the architectural NZCV condition flags and evaluates the condition field every cycle, so writes to registers, memory and PC are suppressed when the condition fails. Sits beside the datapath in the processor top; MemWrite goes to data memory.

Parameters:
FLAG_RESET, 4'b0000, reset value of the {N,Z,C,V} flag register

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
Instr  input  20  instruction bits [31:12]: Cond=[31:28], Op=[27:26], Funct=[25:20], Rd=[15:12]
ALUFlags  input  4  {N,Z,C,V} from the ALU for the current instruction
RegSrc  output  2  register-address mux selects to the datapath
RegWrite  output  1  register file write enable (qualified)
ImmSrc  output  2  extend-unit mode
ALUSrc  output  1  1 = ExtImm, 0 = register
ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR
MemtoReg  output  1  1 = result from ReadData
MemWrite  output  1  data memory write enable (qualified)
PCSrc  output  1  1 = PC loads Result
Flags  output  4  current registered {N,Z,C,V}
Undef  output  1  current instruction not supported; all side effects suppressed

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset: Flags <= FLAG_RESET on the first clk edge with reset=1. While reset=1, RegWrite, MemWrite and PCSrc are forced to 0, and no flag update occurs. Other outputs follow decode.
- Decode is combinational, with zero latency, by Op:
  - 00 data-processing. I=Funct[5], cmd=Funct[4:1], S=Funct[0].
    - Outputs: RegSrc=00, ImmSrc=00, ALUSrc=I, MemtoReg=0, RegW=1.
    - cmd mapping: 0100 ADD->00, 0010 SUB->01, 0000 AND->10, 1100 ORR->11. Any other cmd -> Undef.
  - 01 memory, immediate offset only. Funct[5] must be 0 and U=Funct[3] must be 1; otherwise Undef. L=Funct[0].
    - LDR (L=1): RegSrc=00, ImmSrc=01, ALUSrc=1, ALUControl=00, MemtoReg=1, RegW=1.
    - STR (L=0): RegSrc=10, ImmSrc=01, ALUSrc=1, ALUControl=00, MemtoReg=0, MemW=1.
  - 10 branch. Funct[4] must be 0 (no BL); otherwise Undef.
    - Outputs: RegSrc=01, ImmSrc=10, ALUSrc=1, ALUControl=00, Branch=1.
  - 11 -> Undef.
- Undef: RegW, MemW, Branch and flag writes are all forced to 0. Remaining outputs read 0.
- PCS = Branch | (RegW & Rd==4'hF).
- CondEx is computed from Cond and the registered Flags, not from ALUFlags:
  - EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V
  - HI C&~Z, LS ~C|Z, GE N==V, LT N!=V
  - GT ~Z&(N==V), LE Z|(N!=V), AL 1
  - 1111 -> CondEx=0 and Undef=1.
- Qualified outputs: RegWrite=RegW&CondEx, MemWrite=MemW&CondEx, PCSrc=PCS&CondEx.
- Flag write enables (data-processing only):
  - FlagW[1] = S updates N,Z.
  - FlagW[0] = S & (ADD|SUB) updates C,V. AND/ORR with S preserve C,V.
  - Flags update on the clk edge only if FlagW & CondEx & ~Undef & ~reset.
- Timing: an S instruction's flags are visible to the next instruction's condition, never to its own.
- Back-to-back conditional instructions after a flag-setting instruction use the updated flags the following cycle.

Optional Feature:
- Macro CTRL_CMP_EN.
- Defined: cmd 1010 (CMP) decodes as SUB with RegW=0, FlagW=11. S must be 1; S=0 -> Undef.
- Undefined macro: cmd 1010 -> Undef, no register or flag write.

Test Plan:
- Reset: hold reset 2 cycles while driving E5810004 (STR) -> MemWrite=0, RegWrite=0, PCSrc=0, Flags=0000. Release -> MemWrite=1, RegSrc=10, ImmSrc=01, ALUSrc=1.
- ADDS then BEQ: E0921003 with ALUFlags=0100 -> RegWrite=1, ALUControl=00; next cycle Flags=0100. Then 0A000002 -> PCSrc=1, ImmSrc=10, RegSrc=01. Repeat with ALUFlags=0000 -> PCSrc=0.
- LDR: E5910004 -> RegWrite=1, MemtoReg=1, ALUSrc=1, MemWrite=0.
- PC write: E08FF000 -> PCSrc=1, RegWrite=1.
- Condition fail: Flags Z=0 (ALUFlags=0000 latched by an ADDS), then 00921003 (ADDSEQ) with ALUFlags=1111 -> RegWrite=0, and Flags stay 0000 next cycle.
- CMP E1510002, ALUFlags=0110:
  - CTRL_CMP_EN defined -> RegWrite=0, ALUControl=01, next-cycle Flags=0110.
  - Not defined -> Undef=1, Flags unchanged.
